ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 2, number of cycles _we/_oe held low per access (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept request.
REQ-006 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  7  word address 0..127.
REQ-008 SHALL have port req_wdata  input  16  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  16  read data; 0 for writes.
REQ-011 SHALL have port rsp_err  output  1  write-verify mismatch flag.
REQ-012 SHALL have port ram_adrs  output  7  address to 128x16 RAM.
REQ-013 SHALL have port ram_din  output  16  data to RAM.
REQ-014 SHALL have ports ram_ce_n, ram_we_n, ram_oe_n  output  1 each  active-low RAM strobes.
REQ-015 SHALL have port ram_dout  input  16  data from RAM.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD (plus VSTROBE, VHOLD per REQ-030).
REQ-017 IDLE: req_ready=1, all RAM strobes high; req_valid&req_ready at an edge latches req_wr/addr/wdata and enters SETUP.
REQ-018 req_ready SHALL be 0 in every non-IDLE state; req_valid while busy SHALL be ignored, no queuing.
REQ-019 SETUP (1 cycle): ram_ce_n=0, ram_adrs/ram_din driven from latched values, we_n=oe_n=1.
REQ-020 STROBE (exactly PULSE_CYC cycles): ce_n=0; write drives we_n=0, oe_n=1; read drives oe_n=0, we_n=1.
REQ-021 Read data SHALL be captured from ram_dout at the edge ending the last STROBE cycle.
REQ-022 HOLD (1 cycle): ce_n=0, we_n=oe_n=1, address/data unchanged; rsp_valid=1 this cycle only; next state IDLE.
REQ-023 ram_we_n and ram_oe_n SHALL never be low simultaneously; strobes SHALL only be low while ram_ce_n is low.
REQ-024 Latency: handshake edge to rsp_valid = PULSE_CYC+2 cycles; throughput one access per PULSE_CYC+3 cycles.
REQ-025 ram_adrs/ram_din SHALL be stable from SETUP through HOLD; in IDLE they hold last value.
REQ-026 Addresses 63 and 64 (RAM half boundary) SHALL need no special handling; ram_adrs passes all 7 bits.
REQ-027 Strobe cycle counter SHALL be 4 bits, load PULSE_CYC-1 on STROBE entry, exit at 0.
REQ-028 Unreachable state encodings SHALL return to IDLE next cycle with strobes high.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force IDLE, ram_ce_n=ram_we_n=ram_oe_n=1, req_ready=0 while asserted, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_adrs=0, ram_din=0; access in progress aborted, no response issued.

Configuration
REQ-030 Macro RAM_ACCESS_CTRL_VERIFY_EN defined: write path goes HOLD(no rsp) -> VSTROBE (oe_n=0 for PULSE_CYC cycles, capture) -> VHOLD (rsp_valid=1, rsp_err = captured != latched wdata); write latency becomes 2*PULSE_CYC+4.
REQ-031 Macro undefined: VSTROBE/VHOLD absent, rsp_err tied 0, write latency per REQ-024.

Structure
REQ-032 Shared package ram_ctrl_pkg SHALL hold ADDR_W=7, DATA_W=16 and the FSM state enum.
REQ-033 No sub-module; counter and FSM inline in ram_access_ctrl.

Verification (bench uses behavioural 128x16 RAM model)
REQ-034 Write 0xA5A5 to addr 0x05, PULSE_CYC=2 -> ram_we_n low exactly 2 cycles, rsp_valid 4 cycles after handshake, rsp_err=0.
REQ-035 Read addr 0x05 after REQ-034 -> rsp_rdata=0xA5A5, oe_n low 2 cycles, we_n never low.
REQ-036 Writes 0x1111@63 and 0x2222@64, then reads -> 0x1111 and 0x2222 respectively.
REQ-037 req_valid held high continuously with 3 requests -> exactly 3 accesses, req_ready high only in IDLE, no overlap.
REQ-038 rst_n pulled low during STROBE -> strobes high same cycle, no rsp_valid, next request after release completes normally.
REQ-039 With RAM_ACCESS_CTRL_VERIFY_EN and model forcing bit0 stuck-at-0, write 0x0001 -> rsp_err=1 at latency 8.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared widths and FSM state encoding for the RAM access controller
package ram_ctrl_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        VSTROBE = 3'd4,
        VHOLD   = 3'd5
    } state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - single-port 128x16 async SRAM access sequencer (optional write-verify via RAM_ACCESS_CTRL_VERIFY_EN)
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_adrs,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic              ram_oe_n,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Access sequencer: all strobes and response outputs are registered and set on the transition into each state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_adrs  <= '0;
            ram_din   <= '0;
            ram_ce_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ram_ce_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    if (req_valid && req_ready) begin
                        state     <= SETUP;
                        wr_q      <= req_wr;
                        ram_adrs  <= req_addr;
                        ram_din   <= req_wdata;
                        ram_ce_n  <= 1'b0;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    cnt      <= 4'(PULSE_CYC - 1);
                    ram_we_n <= !wr_q;
                    ram_oe_n <= wr_q;
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state     <= HOLD;
                        ram_we_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                        rsp_rdata <= wr_q ? '0 : ram_dout;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                        // a write answers only after read-back
                        rsp_valid <= !wr_q;
                        err_q     <= 1'b0;
`else
                        rsp_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                    if (wr_q) begin
                        // counter starts one above the pulse length: first VSTROBE cycle is a write-to-read turnaround with oe_n high
                        state <= VSTROBE;
                        cnt   <= 4'(PULSE_CYC);
                    end else begin
                        state     <= IDLE;
                        ram_ce_n  <= 1'b1;
                        req_ready <= 1'b1;
                    end
`else
                    state     <= IDLE;
                    ram_ce_n  <= 1'b1;
                    req_ready <= 1'b1;
`endif
                end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                VSTROBE: begin
                    if (cnt == 4'd0) begin
                        state     <= VHOLD;
                        ram_oe_n  <= 1'b1;
                        err_q     <= (ram_dout != ram_din);
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt      <= cnt - 4'd1;
                        ram_oe_n <= 1'b0;
                    end
                end
                VHOLD: begin
                    state     <= IDLE;
                    ram_ce_n  <= 1'b1;
                    req_ready <= 1'b1;
                end
`endif
                default: begin
                    state     <= IDLE;
                    ram_ce_n  <= 1'b1;
                    ram_we_n  <= 1'b1;
                    ram_oe_n  <= 1'b1;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - scoreboard bench for ram_access_ctrl with behavioural 128x16 RAM
module tb_ram_access_ctrl;

    localparam int P = 2;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    localparam bit          VER   = 1'b1;
    localparam logic [15:0] RMASK = 16'hFFFE;
`else
    localparam bit          VER   = 1'b0;
    localparam logic [15:0] RMASK = 16'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [6:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [6:0]  ram_adrs;
    logic [15:0] ram_din, ram_dout;
    logic        ram_ce_n, ram_we_n, ram_oe_n;

    ram_access_ctrl #(.PULSE_CYC(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_adrs(ram_adrs), .ram_din(ram_din),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // behavioural RAM; bit0 reads stuck at 0 in the verify build
    logic [15:0] mem [128];
    assign ram_dout = mem[ram_adrs] & RMASK;
    always @(posedge clk) if (!ram_ce_n && !ram_we_n) mem[ram_adrs] <= ram_din;

    typedef struct {
        bit          wr;
        logic [15:0] rdata;
        logic        err;
        int          hs;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_mem [128];
    int          cyc = 0;
    int          compared = 0, failed = 0;
    int          we_cnt = 0, oe_cnt = 0;
    int          acc_count = 0, hs_count = 0;
    logic        prev_ce_n = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: protocol rules every cycle, scoreboard pop on every response
    always @(negedge clk) begin
        if (rst_n) begin
            chk("we_oe_exclusive", {31'd0, !ram_we_n && !ram_oe_n}, 0);
            chk("strobe_without_ce", {31'd0, ram_ce_n && (!ram_we_n || !ram_oe_n)}, 0);
            chk("ready_while_busy", {31'd0, !ram_ce_n && req_ready}, 0);
            if (!ram_we_n) we_cnt++;
            if (!ram_oe_n) oe_cnt++;
            if (prev_ce_n && !ram_ce_n) acc_count++;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("latency", cyc - e.hs + 1, e.lat);
                    chk("we_low_cycles", we_cnt, e.wr ? P : 0);
                    chk("oe_low_cycles", oe_cnt, e.wr ? (VER ? P : 0) : P);
                end
                we_cnt = 0;
                oe_cnt = 0;
            end
        end
        prev_ce_n = ram_ce_n;
    end

    // drive a request and hold it until accepted; entry and exit at a negedge
    task automatic issue(input bit wr, input logic [6:0] a, input logic [15:0] d);
        int   waited = 0;
        exp_t e;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("handshake_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        hs_count++;
        e.wr = wr;
        e.hs = cyc;
        if (wr) begin
            ref_mem[a] = d;
            e.rdata    = 16'h0000;
            e.err      = VER && ((d & RMASK) != d);
            e.lat      = VER ? 2 * P + 4 : P + 2;
        end else begin
            e.rdata = ref_mem[a] & RMASK;
            e.err   = 1'b0;
            e.lat   = P + 2;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ce_n", {31'd0, ram_ce_n}, 1);
        chk("reset_we_n", {31'd0, ram_we_n}, 1);
        chk("reset_oe_n", {31'd0, ram_oe_n}, 1);
        chk("reset_ready", {31'd0, req_ready}, 0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("reset_rdata", {16'd0, rsp_rdata}, 0);
        chk("reset_err", {31'd0, rsp_err}, 0);
        chk("reset_adrs", {25'd0, ram_adrs}, 0);
        chk("reset_din", {16'd0, ram_din}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed: basic write/read and the half-boundary addresses
        issue(1'b1, 7'h05, 16'hA5A5); idle(8);
        issue(1'b0, 7'h05, 16'h0000); idle(8);
        issue(1'b1, 7'd63, 16'h1111); idle(2);
        issue(1'b1, 7'd64, 16'h2222); idle(2);
        issue(1'b0, 7'd63, 16'h0000); idle(2);
        issue(1'b0, 7'd64, 16'h0000); idle(2);
        issue(1'b1, 7'h10, 16'h0001); idle(8);

        // three requests with req_valid never dropped
        issue(1'b1, 7'h20, 16'hBEEF);
        issue(1'b0, 7'h20, 16'h0000);
        issue(1'b0, 7'd64, 16'h0000);
        idle(10);

        // reset asserted in the middle of a read strobe
        issue(1'b0, 7'h05, 16'h0000);
        req_valid = 1'b0;
        waited = 0;
        while (ram_oe_n && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("strobe_seen_before_abort", {31'd0, ram_oe_n}, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ce_n", {31'd0, ram_ce_n}, 1);
        chk("abort_oe_n", {31'd0, ram_oe_n}, 1);
        chk("abort_we_n", {31'd0, ram_we_n}, 1);
        chk("abort_ready", {31'd0, req_ready}, 0);
        void'(q.pop_back());
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 0);
        rst_n = 1'b1;
        we_cnt = 0;
        oe_cnt = 0;
        @(negedge clk);
        issue(1'b0, 7'h05, 16'h0000); idle(8);

        // randomized traffic concentrated around the 63/64 boundary
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [6:0]  a;
            logic [15:0] d;
            wr = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(56, 71));
            d  = 16'($urandom);
            issue(wr, a, d);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(1);
        waited = 0;
        while (q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", q.size(), 0);
        chk("access_count", acc_count, hs_count);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
